serial_byte_sender: RTL and testbench

- Transmit-side counterpart of the TOP serial-to-parallel receiver.
- Accepts a parallel byte from a local producer.
- Waits for a fresh rising edge on the receiver's status line, then shifts the byte out LSB-first on a serial data line. Each bit is qualified by a timed write strobe.
- After the last bit it waits for status to drop, pulses done, and returns to idle.

---
 rtl/serial_byte_sender.sv | 138 +++++++++++++
 tb/tb_serial_byte_sender.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_byte_sender.sv
// Serial byte sender: shifts a loaded byte out LSB-first, one strobed bit
// per HIGH/LOW window, after a fresh rising edge on the receiver status line.
module serial_byte_sender #(
    parameter int DATA_WIDTH  = 8,
    parameter int HIGH_CYCLES = 10,
    parameter int LOW_CYCLES  = 10
) (
    input  logic                  clock_1MHz,
    input  logic                  rst,
    input  logic                  load_in,
    input  logic [DATA_WIDTH-1:0] byte_in,
    input  logic                  status_in,
    output logic                  ready_out,
    output logic                  busy_out,
    output logic                  data_out,
    output logic                  write_out,
    output logic                  done_out
);

    localparam int MAXC = (HIGH_CYCLES > LOW_CYCLES) ? HIGH_CYCLES : LOW_CYCLES;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam int BW   = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [CW-1:0] HI_LAST  = CW'(HIGH_CYCLES - 1);
    localparam logic [CW-1:0] LO_LAST  = CW'(LOW_CYCLES - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_RISE,
        BIT_HIGH,
        BIT_LOW,
        WAIT_DROP
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] shr;
    logic [BW-1:0]         bit_q, bit_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  prev_q;
    logic                  data_q, data_d;
    logic                  write_q, write_d;
    logic                  done_q, done_d;
    logic                  rise;

    assign rise      = status_in & ~prev_q;
    assign shr       = shift_q >> 1;
    assign ready_out = (state_q == IDLE);
    assign busy_out  = ~ready_out;
    assign data_out  = data_q;
    assign write_out = write_q;
    assign done_out  = done_q;

    always_ff @(posedge clock_1MHz or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            bit_q   <= '0;
            cnt_q   <= '0;
            prev_q  <= 1'b0;
            data_q  <= 1'b0;
            write_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
            cnt_q   <= cnt_d;
            prev_q  <= status_in;
            data_q  <= data_d;
            write_q <= write_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        bit_d   = bit_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        write_d = write_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (load_in) begin
                    shift_d = byte_in;
                    bit_d   = '0;
                    cnt_d   = '0;
                    state_d = WAIT_RISE;
                end
            end
            WAIT_RISE: begin
                if (rise) begin
                    data_d  = shift_q[0];
                    write_d = 1'b1;
                    cnt_d   = '0;
                    state_d = BIT_HIGH;
                end
            end
            BIT_HIGH: begin
                if (cnt_q == HI_LAST) begin
                    write_d = 1'b0;
                    cnt_d   = '0;
                    state_d = BIT_LOW;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            BIT_LOW: begin
                if (cnt_q == LO_LAST) begin
                    cnt_d = '0;
                    // Next bit goes out with its strobe on the same edge
                    if (bit_q < BIT_LAST) begin
                        shift_d = shr;
                        bit_d   = bit_q + BW'(1);
                        data_d  = shr[0];
                        write_d = 1'b1;
                        state_d = BIT_HIGH;
                    end else begin
                        state_d = WAIT_DROP;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            WAIT_DROP: begin
                if (!status_in) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_serial_byte_sender.sv
// Directed bench for serial_byte_sender: default timing instance plus a
// HIGH_CYCLES=LOW_CYCLES=1 instance for the fast-strobe case.
module tb_serial_byte_sender;

    logic       clk = 1'b0;
    logic       rst;
    logic       load0, load1, st0, st1;
    logic [7:0] byte0, byte1;
    logic       ready0, busy0, data0, wr0, done0;
    logic       ready1, busy1, data1, wr1, done1;
    logic       sel;
    logic       mw, md, mdone, mready;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_byte_sender dut (
        .clock_1MHz (clk),
        .rst        (rst),
        .load_in    (load0),
        .byte_in    (byte0),
        .status_in  (st0),
        .ready_out  (ready0),
        .busy_out   (busy0),
        .data_out   (data0),
        .write_out  (wr0),
        .done_out   (done0)
    );

    serial_byte_sender #(.DATA_WIDTH(8), .HIGH_CYCLES(1), .LOW_CYCLES(1)) dut1 (
        .clock_1MHz (clk),
        .rst        (rst),
        .load_in    (load1),
        .byte_in    (byte1),
        .status_in  (st1),
        .ready_out  (ready1),
        .busy_out   (busy1),
        .data_out   (data1),
        .write_out  (wr1),
        .done_out   (done1)
    );

    assign mw     = sel ? wr1 : wr0;
    assign md     = sel ? data1 : data0;
    assign mdone  = sel ? done1 : done0;
    assign mready = sel ? ready1 : ready0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load_byte(input logic [7:0] v, input string tag);
        load0 = 1'b1;
        byte0 = v;
        @(negedge clk);
        load0 = 1'b0;
        chk({tag, " accepted"}, 32'(ready0), 32'd0);
    endtask

    // Call on the negedge where status was just raised; drops status at the end
    task automatic frame(input logic [7:0] exp, input int h, input int l,
                         input int inj, input string tag);
        int bad;
        int b;
        int ph;
        logic [7:0] got;
        bad = 0;
        got = '0;
        for (int n = 0; n < 8 * (h + l); n++) begin
            @(negedge clk);
            b  = n / (h + l);
            ph = n % (h + l);
            if (n == 0) chk({tag, " first strobe"}, 32'(mw), 32'd1);
            if (ph == 0) got[b] = md;
            if (mw !== (ph < h)) bad++;
            if (md !== exp[b]) bad++;
            if (mdone !== 1'b0 || mready !== 1'b0) bad++;
            load0 = (b == inj && ph == 0);
            if (b == inj && ph == 0) byte0 = 8'h55;
            if (n == 8 * (h + l) - 1) begin
                st0 = 1'b0;
                st1 = 1'b0;
            end
        end
        load0 = 1'b0;
        chk({tag, " bits"}, 32'(got), 32'(exp));
        chk({tag, " shape"}, 32'(bad), 32'd0);
    endtask

    task automatic finish_frame(input string tag);
        @(negedge clk);
        chk({tag, " done early"}, 32'(mdone), 32'd0);
        @(negedge clk);
        chk({tag, " done pulse"}, 32'(mdone), 32'd1);
        chk({tag, " ready"}, 32'(mready), 32'd1);
        @(negedge clk);
        chk({tag, " done one cycle"}, 32'(mdone), 32'd0);
    endtask

    initial begin
        int cnt;
        sel   = 1'b0;
        rst   = 1'b0;
        load0 = 1'b0;
        load1 = 1'b0;
        st0   = 1'b0;
        st1   = 1'b0;
        byte0 = '0;
        byte1 = '0;

        // 1: reset with random inputs
        for (int i = 0; i < 3; i++) begin
            load0 = 1'($urandom);
            st0   = 1'($urandom);
            byte0 = 8'($urandom);
            load1 = 1'($urandom);
            st1   = 1'($urandom);
            @(negedge clk);
            chk("rst outs", 32'({data0, wr0, done0, ready0, busy0}), 32'b00010);
            #7;
            chk("rst outs mid", 32'({data0, wr0, done0, ready0, busy0}), 32'b00010);
        end
        chk("rst outs dut1", 32'({data1, wr1, done1, ready1, busy1}), 32'b00010);
        @(negedge clk);
        load0 = 1'b0;
        load1 = 1'b0;
        st0   = 1'b0;
        st1   = 1'b0;
        rst   = 1'b1;
        @(negedge clk);

        // 2: basic frame 0xAA
        load_byte(8'hAA, "t2");
        st0 = 1'b1;
        frame(8'hAA, 10, 10, -1, "t2");
        finish_frame("t2");

        // 3: status already high must fall and rise again
        st0 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        load_byte(8'h3C, "t3");
        cnt = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (wr0 !== 1'b0 || ready0 !== 1'b0) cnt++;
        end
        chk("t3 no start", 32'(cnt), 32'd0);
        st0 = 1'b0;
        @(negedge clk);
        st0 = 1'b1;
        frame(8'h3C, 10, 10, -1, "t3");
        finish_frame("t3");

        // 4: load while busy ignored
        load_byte(8'h81, "t4");
        st0 = 1'b1;
        frame(8'h81, 10, 10, 2, "t4");
        finish_frame("t4");
        cnt = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (wr0 !== 1'b0 || ready0 !== 1'b1) cnt++;
            if (i == 10) st0 = 1'b1;
        end
        chk("t4 no second frame", 32'(cnt), 32'd0);
        st0 = 1'b0;
        @(negedge clk);

        // 5: reset mid-frame in bit 3 HIGH
        load_byte(8'hFF, "t5");
        st0 = 1'b1;
        repeat (63) @(negedge clk);
        chk("t5 pre-reset", 32'({data0, wr0}), 32'b11);
        #2 rst = 1'b0;
        #1 chk("t5 async reset", 32'({data0, wr0, done0, ready0, busy0}), 32'b00010);
        st0 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (wr0 !== 1'b0 || done0 !== 1'b0 || ready0 !== 1'b1) cnt++;
            if (i == 5) st0 = 1'b1;
        end
        chk("t5 byte discarded", 32'(cnt), 32'd0);
        st0 = 1'b0;
        @(negedge clk);
        load_byte(8'h0F, "t5b");
        st0 = 1'b1;
        frame(8'h0F, 10, 10, -1, "t5b");
        finish_frame("t5b");

        // 6: single-cycle HIGH/LOW instance
        sel   = 1'b1;
        load1 = 1'b1;
        byte1 = 8'h01;
        @(negedge clk);
        load1 = 1'b0;
        chk("t6 accepted", 32'(ready1), 32'd0);
        st1 = 1'b1;
        frame(8'h01, 1, 1, -1, "t6");
        finish_frame("t6");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
